glyph_row_sequencer: RTL

Sequences one character-ROM row read and serializes the returned glyph byte into a pixel stream. Sits between the VGA timing logic and the ROM read controller. It drives digit code, row offset and read strobe toward the ROM controller, captures the returned byte, then shifts it out MSB-first with an optional horizontal repeat factor. It handles one glyph row per `start` pulse.

---
 rtl/glyph_row_sequencer_pkg.sv | 24 ++
 rtl/glyph_row_sequencer_glyph_shifter.sv | 57 +++++
 rtl/glyph_row_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/glyph_row_sequencer_pkg.sv
// Shared types and constants for the glyph row sequencer and its shifter.
package glyph_row_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    STROBE  = 3'd2,
    CAPTURE = 3'd3,
    SHIFT   = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam int GLYPH_WIDTH = 8;
  localparam int ROW_BITS    = 4;
  localparam int BLANK_BIT   = 2;
  localparam int DIGIT_BITS  = 3;
  localparam int CNT_BITS    = 3;

  // Codes with the blank bit set never touch the ROM and emit an all-zero row.
  function automatic logic is_blank(input logic [DIGIT_BITS-1:0] code);
    return code[BLANK_BIT];
  endfunction

endpackage

// File: rtl/glyph_row_sequencer_glyph_shifter.sv
// Glyph byte shift register with per-bit repeat counter; emits MSB first.
module glyph_shifter
  import glyph_row_sequencer_pkg::*;
#(
  parameter int PIXEL_REPEAT = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_load,
  input  logic                   i_enable,
  input  logic [GLYPH_WIDTH-1:0] i_data,
  output logic                   o_msb,
  output logic                   o_last
);

  localparam logic [CNT_BITS-1:0] REP_TC = CNT_BITS'(PIXEL_REPEAT - 1);
  localparam logic [CNT_BITS-1:0] BIT_TC = CNT_BITS'(GLYPH_WIDTH - 1);

  logic [GLYPH_WIDTH-1:0] r_shift;
  logic [CNT_BITS-1:0]    r_bit_cnt;
  logic [CNT_BITS-1:0]    r_rep_cnt;
  logic                   w_rep_tc;

  assign w_rep_tc = (r_rep_cnt == REP_TC);
  assign o_msb    = r_shift[GLYPH_WIDTH-1];
  assign o_last   = w_rep_tc && (r_bit_cnt == BIT_TC);

  // Load, repeat-hold and shift; the bit counter saturates at 7 and only a load clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shift   <= {GLYPH_WIDTH{1'b0}};
      r_bit_cnt <= {CNT_BITS{1'b0}};
      r_rep_cnt <= {CNT_BITS{1'b0}};
    end else if (i_load) begin
      r_shift   <= i_data;
      r_bit_cnt <= {CNT_BITS{1'b0}};
      r_rep_cnt <= {CNT_BITS{1'b0}};
    end else if (i_enable) begin
      if (w_rep_tc) begin
        r_shift   <= {r_shift[GLYPH_WIDTH-2:0], 1'b0};
        r_rep_cnt <= {CNT_BITS{1'b0}};
        if (r_bit_cnt != BIT_TC) begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end else begin
          r_bit_cnt <= r_bit_cnt;
        end
      end else begin
        r_rep_cnt <= r_rep_cnt + 3'd1;
      end
    end else begin
      r_shift   <= r_shift;
      r_bit_cnt <= r_bit_cnt;
      r_rep_cnt <= r_rep_cnt;
    end
  end

endmodule

// File: rtl/glyph_row_sequencer.sv
// Fetches one glyph row from the character ROM and serializes it to a pixel stream.
module glyph_row_sequencer
  import glyph_row_sequencer_pkg::*;
#(
  parameter int PIXEL_REPEAT = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DIGIT_BITS-1:0]  digit,
  input  logic [ROW_BITS-1:0]    rowIdx,
  output logic [DIGIT_BITS-1:0]  romNum,
  output logic [ROW_BITS-1:0]    romOffset,
  output logic                   romEnable,
  input  logic [GLYPH_WIDTH-1:0] romByte,
  output logic                   pixelOut,
  output logic                   pixelValid,
  output logic                   busy,
  output logic                   done
);

  state_e                 r_state;
  state_e                 w_next;
  logic                   w_accept;
  logic                   w_blank;
  logic                   w_load;
  logic                   w_enable;
  logic                   w_last;
  logic [GLYPH_WIDTH-1:0] w_load_data;
  logic [DIGIT_BITS-1:0]  r_rom_num;
  logic [ROW_BITS-1:0]    r_rom_offset;
  logic                   r_rom_enable;
  logic                   r_pixel_valid;
  logic                   r_busy;
  logic                   r_done;

  assign w_blank     = is_blank(r_rom_num);
  assign w_load      = (r_state == CAPTURE);
  assign w_enable    = (r_state == SHIFT);
  assign w_load_data = w_blank ? 8'h00 : romByte;

  glyph_shifter #(
    .PIXEL_REPEAT (PIXEL_REPEAT)
  ) u_shifter (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_load),
    .i_enable (w_enable),
    .i_data   (w_load_data),
    .o_msb    (pixelOut),
    .o_last   (w_last)
  );

  // Next-state decode; start is only honoured in IDLE.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next   = ADDR;
          w_accept = 1'b1;
        end else begin
          w_next   = IDLE;
        end
      end
      ADDR:    w_next = STROBE;
      STROBE:  w_next = CAPTURE;
      CAPTURE: w_next = SHIFT;
      SHIFT: begin
        if (w_last) begin
          w_next = DONE;
        end else begin
          w_next = SHIFT;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_rom_num     <= {DIGIT_BITS{1'b0}};
      r_rom_offset  <= {ROW_BITS{1'b0}};
      r_rom_enable  <= 1'b0;
      r_pixel_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_rom_num    <= digit;
        r_rom_offset <= rowIdx;
      end else begin
        r_rom_num    <= r_rom_num;
        r_rom_offset <= r_rom_offset;
      end
      r_rom_enable  <= (w_next == STROBE) && !w_blank;
      r_pixel_valid <= (w_next == SHIFT);
      r_busy        <= (w_next != IDLE);
      r_done        <= (w_next == DONE);
    end
  end

  assign romNum     = r_rom_num;
  assign romOffset  = r_rom_offset;
  assign romEnable  = r_rom_enable;
  assign pixelValid = r_pixel_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
